user_stream_endpoint: RTL and testbench

//  User-side endpoint for one leaf_interface stream port, on the clk_user domain.

---
 rtl/user_stream_endpoint_if.sv | 30 +++
 rtl/user_stream_endpoint.sv | 124 ++++++++++++
 tb/tb_user_stream_endpoint.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/user_stream_endpoint_if.sv
// Handshake bundle between a leaf_interface stream port and its user-side endpoint.
// The slave modport is the endpoint's view; the master modport is the leaf interface's view.
interface user_stream_endpoint_if #(
  parameter int PAYLOAD_BITS = 32
);
  logic [PAYLOAD_BITS-1:0] din_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;
  logic [PAYLOAD_BITS-1:0] dout_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;

  modport slave (
    input  din_interface2user,
    input  vld_interface2user,
    output ack_user2interface,
    output dout_user2interface,
    output vld_user2interface,
    input  ack_interface2user
  );

  modport master (
    output din_interface2user,
    output vld_interface2user,
    input  ack_user2interface,
    input  dout_user2interface,
    input  vld_user2interface,
    output ack_interface2user
  );
endinterface

// File: rtl/user_stream_endpoint.sv
// Loopback endpoint: buffers words from the leaf interface in a FIFO, returns them,
// and appends a wrap-around checksum word after every FRAME_LEN payload words.
module user_stream_endpoint #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_BITS    = 4,
  parameter int FRAME_LEN    = 8
) (
  input  logic                 clk_user,
  input  logic                 reset,
  user_stream_endpoint_if.slave stream,
  output logic [ADDR_BITS:0]   fifo_level,
  output logic [15:0]          frames_sent
);

  localparam int BEAT_BITS = $clog2(FRAME_LEN + 1);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT  = BEAT_BITS'(FRAME_LEN - 1);
  localparam logic [ADDR_BITS:0]   FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic {S_DATA, S_SUM} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]    wr_ptr;
  logic [ADDR_BITS-1:0]    rd_ptr;
  logic [ADDR_BITS:0]      count;
  logic [PAYLOAD_BITS-1:0] sum;
  logic [PAYLOAD_BITS-1:0] dout;
  logic [BEAT_BITS-1:0]    beat;
  logic                    vld;
  logic                    dout_is_sum;
  logic                    full;
  logic                    empty;
  logic                    out_free;
  logic                    push;
  logic                    pop;
  logic                    load_sum;

  assign full     = (count == FULL_LEVEL);
  assign empty    = (count == '0);
  assign out_free = !vld || stream.ack_interface2user;
  assign push     = stream.vld_interface2user && stream.ack_user2interface;

  assign stream.ack_user2interface  = !reset && !full;
  assign stream.dout_user2interface = dout;
  assign stream.vld_user2interface  = vld;
  assign fifo_level                 = count;

  always_ff @(posedge clk_user) begin
    if (reset) state <= S_DATA;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_DATA:  if (pop && beat == LAST_BEAT) state_next = S_SUM;
      S_SUM:   if (out_free) state_next = S_DATA;
      default: state_next = S_DATA;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    load_sum = 1'b0;
    case (state)
      S_DATA:  pop      = out_free && !empty;
      S_SUM:   load_sum = out_free;
      default: ;
    endcase
  end

  // Storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge clk_user) begin
    if (push) mem[wr_ptr] <= stream.din_interface2user;
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      dout        <= '0;
      vld         <= 1'b0;
      dout_is_sum <= 1'b0;
      sum         <= '0;
      beat        <= '0;
      frames_sent <= '0;
    end else begin
      if (vld && stream.ack_interface2user && dout_is_sum)
        frames_sent <= frames_sent + 1'b1;
      if (pop) begin
        dout        <= mem[rd_ptr];
        vld         <= 1'b1;
        dout_is_sum <= 1'b0;
        sum         <= sum + mem[rd_ptr];
        beat        <= beat + 1'b1;
      end else if (load_sum) begin
        dout        <= sum;
        vld         <= 1'b1;
        dout_is_sum <= 1'b1;
        sum         <= '0;
        beat        <= '0;
      end else if (out_free) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_user_stream_endpoint.sv
// Directed bench for user_stream_endpoint (FRAME_LEN=4, DEPTH=16); expected words
// are queued as stimulus is accepted and a negedge monitor checks every delivered word.
module tb_user_stream_endpoint;

  localparam int PB = 32;

  logic        clk_user = 1'b0;
  logic        reset    = 1'b1;
  logic [4:0]  fifo_level;
  logic [15:0] frames_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc_cyc = 0;
  int rise_cyc     = 0;

  logic [PB-1:0] exp_q[$];
  logic          prev_hold = 1'b0;
  logic          prev_vld  = 1'b0;
  logic [PB-1:0] prev_dout = '0;

  user_stream_endpoint_if #(.PAYLOAD_BITS(PB)) bus ();

  user_stream_endpoint #(
    .PAYLOAD_BITS(PB),
    .DEPTH(16),
    .ADDR_BITS(4),
    .FRAME_LEN(4)
  ) dut (
    .clk_user(clk_user),
    .reset(reset),
    .stream(bus),
    .fifo_level(fifo_level),
    .frames_sent(frames_sent)
  );

  always #5 clk_user = ~clk_user;
  always @(posedge clk_user) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [PB-1:0] actual, input logic [PB-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: stability while stalled, then in-order comparison of each handshake.
  always @(negedge clk_user) begin
    if (reset) begin
      prev_hold = 1'b0;
      prev_vld  = 1'b0;
    end else begin
      if (prev_hold) begin
        check_output("hold_vld", {31'd0, bus.vld_user2interface}, 32'd1);
        check_output("hold_dout", bus.dout_user2interface, prev_dout);
      end
      if (bus.vld_user2interface && bus.ack_interface2user) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got 0x%08h expected none", bus.dout_user2interface);
        end else begin
          check_output("stream_word", bus.dout_user2interface, exp_q.pop_front());
        end
      end
      if (bus.vld_user2interface && !prev_vld) rise_cyc = cyc;
      prev_hold = bus.vld_user2interface && !bus.ack_interface2user;
      prev_dout = bus.dout_user2interface;
      prev_vld  = bus.vld_user2interface;
    end
  end

  task automatic apply_stimulus(input logic [PB-1:0] word);
    int waited = 0;
    bus.din_interface2user = word;
    bus.vld_interface2user = 1'b1;
    @(negedge clk_user);
    while (!bus.ack_user2interface && waited < 50) begin
      @(negedge clk_user);
      waited++;
    end
    if (bus.ack_user2interface) begin
      last_acc_cyc = cyc;
      exp_q.push_back(word);
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got ack=0 expected ack=1 for 0x%08h", word);
    end
    @(posedge clk_user);
    #1;
    bus.vld_interface2user = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    bus.ack_interface2user = 1'b1;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk_user);
      waited++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk_user);
    #1;
  endtask

  logic [PB-1:0] t3_sums [5] = '{32'h406, 32'h416, 32'h426, 32'h436, 32'h446};
  logic [PB-1:0] t5_words[4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0};
  int t2_acc;

  initial begin
    bus.din_interface2user = '0;
    bus.vld_interface2user = 1'b0;
    bus.ack_interface2user = 1'b0;

    // T1: reset for three cycles, then idle
    @(negedge clk_user);
    check_output("ack_in_reset", {31'd0, bus.ack_user2interface}, 32'd0);
    repeat (2) @(posedge clk_user);
    @(posedge clk_user);
    #1;
    reset = 1'b0;
    @(negedge clk_user);
    check_output("rst_vld", {31'd0, bus.vld_user2interface}, 32'd0);
    check_output("rst_dout", bus.dout_user2interface, 32'd0);
    check_output("rst_level", 32'(fifo_level), 32'd0);
    check_output("rst_frames", 32'(frames_sent), 32'd0);
    check_output("rst_ack_after", {31'd0, bus.ack_user2interface}, 32'd1);

    // T2: one frame back-to-back with the output always ready
    @(posedge clk_user);
    #1;
    bus.ack_interface2user = 1'b1;
    apply_stimulus(32'd1);
    t2_acc = last_acc_cyc;
    apply_stimulus(32'd2);
    apply_stimulus(32'd3);
    apply_stimulus(32'd4);
    exp_q.push_back(32'd10);
    drain();
    check_output("t2_latency", 32'(rise_cyc - t2_acc), 32'd2);
    check_output("t2_frames", 32'(frames_sent), 32'd1);

    // T5: checksum wraps modulo 2^32
    foreach (t5_words[i]) apply_stimulus(t5_words[i]);
    exp_q.push_back(32'h0000_0001);
    drain();
    check_output("t5_frames", 32'(frames_sent), 32'd2);

    // T3: output stalled; one word parks in the output register, sixteen fill the FIFO
    bus.ack_interface2user = 1'b0;
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(32'h100 + 32'(i));
      if (i % 4 == 3) exp_q.push_back(t3_sums[i / 4]);
    end
    @(negedge clk_user);
    check_output("t3_level", 32'(fifo_level), 32'd16);
    check_output("t3_ack_full", {31'd0, bus.ack_user2interface}, 32'd0);
    check_output("t3_head_dout", bus.dout_user2interface, 32'h100);

    // T4: pop and offered push in the same cycle at full; the push waits one cycle
    @(posedge clk_user);
    #1;
    bus.din_interface2user = 32'h111;
    bus.vld_interface2user = 1'b1;
    bus.ack_interface2user = 1'b1;
    @(negedge clk_user);
    check_output("t4_ack_at_full", {31'd0, bus.ack_user2interface}, 32'd0);
    @(posedge clk_user);
    #1;
    bus.ack_interface2user = 1'b0;
    @(negedge clk_user);
    check_output("t4_level_after_pop", 32'(fifo_level), 32'd15);
    check_output("t4_ack_next", {31'd0, bus.ack_user2interface}, 32'd1);
    exp_q.push_back(32'h111);
    @(posedge clk_user);
    #1;
    bus.vld_interface2user = 1'b0;
    @(negedge clk_user);
    check_output("t4_level", 32'(fifo_level), 32'd16);
    @(posedge clk_user);
    #1;
    bus.ack_interface2user = 1'b1;
    apply_stimulus(32'h112);
    apply_stimulus(32'h113);
    exp_q.push_back(t3_sums[4]);
    drain();
    check_output("t3_frames", 32'(frames_sent), 32'd7);

    // T6: reset mid-frame discards buffered words and the partial sum
    bus.ack_interface2user = 1'b0;
    apply_stimulus(32'hAA);
    apply_stimulus(32'hBB);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk_user);
    check_output("t6_ack_reset", {31'd0, bus.ack_user2interface}, 32'd0);
    @(posedge clk_user);
    #1;
    reset = 1'b0;
    @(negedge clk_user);
    check_output("t6_level", 32'(fifo_level), 32'd0);
    check_output("t6_vld", {31'd0, bus.vld_user2interface}, 32'd0);
    check_output("t6_frames_rst", 32'(frames_sent), 32'd0);
    @(posedge clk_user);
    #1;
    bus.ack_interface2user = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(32'd5);
    exp_q.push_back(32'h14);
    drain();
    check_output("t6_frames", 32'(frames_sent), 32'd1);
    check_output("t6_idle_vld", {31'd0, bus.vld_user2interface}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
